// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns PC and IR, handshakes with instruction
// and data memory, and produces the commit strobe that qualifies architectural writes.
module pc_sequencer #(
  parameter int unsigned PC_WIDTH     = 10,
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned RETIRE_WIDTH = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_n_i,
  input  logic                    start_i,
  output logic                    imem_req_o,
  output logic [PC_WIDTH-1:0]     imem_addr_o,
  input  logic                    imem_ack_i,
  input  logic [7:0]              imem_data_i,
  output logic [7:0]              ir_o,
  output logic [PC_WIDTH-1:0]     pc_o,
  input  logic                    memread_i,
  input  logic                    memwrite_i,
  input  logic                    branchf_i,
  input  logic                    branchb_i,
  input  logic                    done_i,
  input  logic [7:0]              offset_i,
  output logic                    dmem_req_o,
  input  logic                    dmem_ack_i,
  output logic                    commit_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [RETIRE_WIDTH-1:0] retired_o
);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StHalt, StErr} state_e;

  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [7:0]              ir_q, ir_d;
  logic [RETIRE_WIDTH-1:0] retired_q, retired_d;
  logic [7:0]              wait_q, wait_d;

  logic                    imem_req, dmem_req, commit, done, err, restart;
  logic [PC_WIDTH-1:0]     pc_inc, pc_target, off_ext;

  assign off_ext = PC_WIDTH'(offset_i);
  assign pc_inc  = pc_q + PC_WIDTH'(1);

  // Forward branch wins when the decoder flags both directions.
  always_comb begin
    pc_target = pc_inc;
    if (branchf_i)      pc_target = pc_q + off_ext;
    else if (branchb_i) pc_target = pc_q - off_ext;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    wait_d    = wait_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    commit    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    restart   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) restart = 1'b1;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack_i) begin
          ir_d    = imem_data_i;
          state_d = StExec;
        end
      end
      StExec: begin
        if (done_i) begin
          state_d = StHalt;
        end else if (memread_i || memwrite_i) begin
          wait_d  = 8'd0;
          state_d = StMem;
        end else begin
          commit  = 1'b1;
          pc_d    = pc_target;
          state_d = StFetch;
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        if (dmem_ack_i) begin
          commit  = 1'b1;
          pc_d    = pc_inc;
          state_d = StFetch;
        end else begin
          // wait_d counts MEM cycles that passed without an ack.
          wait_d = wait_q + 8'd1;
          if (wait_d == 8'(MEM_TIMEOUT)) state_d = StErr;
        end
      end
      StHalt: begin
        done = 1'b1;
        if (start_i) restart = 1'b1;
      end
      StErr: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (restart) begin
      pc_d      = '0;
      retired_d = '0;
      state_d   = StFetch;
    end

    if (commit && (retired_q != {RETIRE_WIDTH{1'b1}})) begin
      retired_d = retired_q + RETIRE_WIDTH'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

  // The flop reset forces StIdle, so every strobe below drops as soon as reset asserts.
  assign imem_req_o  = imem_req;
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign ir_o        = ir_q;
  assign dmem_req_o  = dmem_req;
  assign commit_o    = commit;
  assign done_o      = done;
  assign err_o       = err;
  assign retired_o   = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: per-cycle comparison against a behavioural model, directed
// scenarios with literal expectations, and randomized episodes.
module tb_pc_sequencer;

  localparam int PCW  = 10;
  localparam int TO   = 15;
  localparam int RW   = 16;
  localparam int PCM  = 1 << PCW;
  localparam int RMAX = (1 << RW) - 1;

  localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_MEM = 3, P_HALT = 4, P_ERR = 5;

  logic           clock, reset_n, start;
  logic           imem_req, imem_ack, dmem_req, dmem_ack;
  logic [PCW-1:0] imem_addr, pc;
  logic [7:0]     imem_data, ir, offset;
  logic           memread, memwrite, branchf, branchb, done_in;
  logic           commit, done, err;
  logic [RW-1:0]  retired;

  pc_sequencer #(.PC_WIDTH(PCW), .MEM_TIMEOUT(TO), .RETIRE_WIDTH(RW)) dut (
    .clock_i(clock), .reset_n_i(reset_n), .start_i(start),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack),
    .imem_data_i(imem_data), .ir_o(ir), .pc_o(pc),
    .memread_i(memread), .memwrite_i(memwrite), .branchf_i(branchf), .branchb_i(branchb),
    .done_i(done_in), .offset_i(offset), .dmem_req_o(dmem_req), .dmem_ack_i(dmem_ack),
    .commit_o(commit), .done_o(done), .err_o(err), .retired_o(retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int n_commit, n_dreq;

  // Model state
  int m_ph, m_pc, m_ir, m_ret, m_wait;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_pc = 0; m_ir = 0; m_ret = 0; m_wait = 0;
  endtask

  // Called just after a negedge with inputs already applied; returns at the next negedge.
  task automatic cycle();
    bit e_commit;
    int tgt;
    #1;
    e_commit = (m_ph == P_EXEC && !done_in && !(memread || memwrite)) ||
               (m_ph == P_MEM && dmem_ack);
    check("imem_req", 32'(imem_req), 32'(m_ph == P_FETCH));
    check("dmem_req", 32'(dmem_req), 32'(m_ph == P_MEM));
    check("commit",   32'(commit),   32'(e_commit));
    check("done",     32'(done),     32'(m_ph == P_HALT || m_ph == P_ERR));
    check("err",      32'(err),      32'(m_ph == P_ERR));
    check("pc",       32'(pc),       32'(m_pc));
    check("imem_addr", 32'(imem_addr), 32'(m_pc));
    check("ir",       32'(ir),       32'(m_ir));
    check("retired",  32'(retired),  32'(m_ret));
    if (commit)   n_commit++;
    if (dmem_req) n_dreq++;

    if (e_commit && m_ret < RMAX) m_ret++;
    case (m_ph)
      P_IDLE, P_HALT: if (start) begin m_pc = 0; m_ret = 0; m_ph = P_FETCH; end
      P_FETCH: if (imem_ack) begin m_ir = int'(imem_data); m_ph = P_EXEC; end
      P_EXEC: begin
        if (done_in) m_ph = P_HALT;
        else if (memread || memwrite) begin m_wait = 0; m_ph = P_MEM; end
        else begin
          if (branchf)      tgt = m_pc + int'(offset);
          else if (branchb) tgt = m_pc + PCM - int'(offset);
          else              tgt = m_pc + 1;
          m_pc = tgt % PCM;
          m_ph = P_FETCH;
        end
      end
      P_MEM: begin
        if (dmem_ack) begin m_pc = (m_pc + 1) % PCM; m_ph = P_FETCH; end
        else begin
          m_wait++;
          if (m_wait >= TO) m_ph = P_ERR;
        end
      end
      default: ;
    endcase
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    start = 0; imem_ack = 0; imem_data = 0; memread = 0; memwrite = 0;
    branchf = 0; branchb = 0; done_in = 0; offset = 0; dmem_ack = 0;
  endtask

  task automatic fetch(input int iwait, input logic [7:0] data);
    for (int i = 0; i < iwait; i++) begin
      imem_ack = 0; imem_data = 8'($urandom); cycle();
    end
    imem_ack = 1; imem_data = data; cycle();
    imem_ack = 0;
  endtask

  task automatic exec(input bit mem, input bit bf, input bit bb, input bit dn,
                      input logic [7:0] off);
    memread = mem; branchf = bf; branchb = bb; done_in = dn; offset = off;
    cycle();
    memread = 0; branchf = 0; branchb = 0; done_in = 0; offset = 0;
  endtask

  task automatic mem_phase(input int dwait);
    for (int i = 0; i < dwait && i < TO; i++) begin
      dmem_ack = 0; cycle();
    end
    if (dwait < TO) begin
      dmem_ack = 1; cycle();
      dmem_ack = 0;
    end
  endtask

  task automatic instr(input bit bf, input bit bb, input logic [7:0] off);
    fetch(0, 8'($urandom));
    exec(1'b0, bf, bb, 1'b0, off);
  endtask

  task automatic async_reset();
    #2 reset_n = 0;
    #1;
    model_reset();
    check("rst_async_pc", 32'(pc), 32'd0);
    check("rst_async_dreq", 32'(dmem_req), 32'd0);
    check("rst_async_ireq", 32'(imem_req), 32'd0);
    check("rst_async_flags", {29'd0, commit, done, err}, 32'd0);
    check("rst_async_ret", 32'(retired), 32'd0);
    check("rst_async_ir", 32'(ir), 32'd0);
    @(negedge clock);
    reset_n = 1;
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1;
    cycle();
    check("reset_pc", 32'(pc), 32'd0);
    check("reset_flags", {28'd0, imem_req, dmem_req, done, err}, 32'd0);

    // Straight-line program: three plain instructions then halt.
    start = 1; cycle(); start = 0;
    n_commit = 0;
    for (int i = 0; i < 3; i++) instr(1'b0, 1'b0, 8'd0);
    fetch(0, 8'h3C);
    exec(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    check("sl_commits", 32'(n_commit), 32'd3);
    check("sl_done", 32'(done), 32'd1);
    check("sl_pc", 32'(pc), 32'd3);
    check("sl_retired", 32'(retired), 32'd3);
    repeat (2) cycle();
    check("halt_frozen_pc", 32'(pc), 32'd3);

    // Restart from HALT.
    start = 1; cycle(); start = 0;
    check("restart_pc", 32'(pc), 32'd0);
    check("restart_ret", 32'(retired), 32'd0);
    check("restart_done", 32'(done), 32'd0);
    for (int i = 0; i < 5; i++) instr(1'b0, 1'b0, 8'd0);
    check("pc_at_5", 32'(pc), 32'd5);
    instr(1'b1, 1'b0, 8'd4);
    check("branchf_addr", 32'(imem_addr), 32'd9);
    instr(1'b0, 1'b1, 8'd4);
    check("branchb_to_5", 32'(pc), 32'd5);
    instr(1'b1, 1'b1, 8'd4);
    check("both_branch", 32'(imem_addr), 32'd9);
    instr(1'b0, 1'b1, 8'd7);
    check("pc_at_2", 32'(pc), 32'd2);
    instr(1'b0, 1'b1, 8'd5);
    check("branchb_wrap", 32'(pc), 32'd1021);

    // Slow fetch: IR holds until the ack.
    fetch(5, 8'hA5);
    check("slow_fetch_ir", 32'(ir), 32'hA5);
    // Load with ack after three wait cycles.
    n_dreq = 0; n_commit = 0;
    exec(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    mem_phase(3);
    check("load_dreq_cycles", 32'(n_dreq), 32'd4);
    check("load_commits", 32'(n_commit), 32'd1);
    check("load_pc", 32'(pc), 32'd1022);
    // Store acked on the final allowed cycle.
    fetch(0, 8'h11);
    memwrite = 1; exec(1'b0, 1'b0, 1'b0, 1'b0, 8'd0); memwrite = 0;
    mem_phase(TO - 1);
    check("late_ack_err", 32'(err), 32'd0);
    check("late_ack_pc", 32'(pc), 32'd1023);
    // Store that never gets an ack.
    fetch(0, 8'h22);
    memwrite = 1; exec(1'b0, 1'b0, 1'b0, 1'b0, 8'd0); memwrite = 0;
    n_dreq = 0;
    mem_phase(TO);
    check("timeout_dreq_cycles", 32'(n_dreq), 32'd15);
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_done", 32'(done), 32'd1);
    start = 1; repeat (3) cycle(); start = 0;
    check("err_ignores_start", 32'(err), 32'd1);
    check("err_pc_frozen", 32'(pc), 32'd1023);

    // Async reset in the middle of a data access.
    async_reset();
    cycle();
    start = 1; cycle(); start = 0;
    fetch(1, 8'h44);
    exec(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    dmem_ack = 0; repeat (2) cycle();
    check("pre_reset_dreq", 32'(dmem_req), 32'd1);
    async_reset();
    repeat (3) cycle();
    check("post_reset_idle", 32'(imem_req), 32'd0);

    // Randomized episodes.
    for (int ep = 0; ep < 20; ep++) begin
      async_reset();
      for (int c = 0; c < 300; c++) begin
        start     = ($urandom_range(0, 9) == 0);
        imem_ack  = ($urandom_range(0, 1) == 0);
        imem_data = 8'($urandom);
        done_in   = ($urandom_range(0, 19) == 0);
        memread   = ($urandom_range(0, 9) == 0);
        memwrite  = ($urandom_range(0, 9) == 0);
        branchf   = ($urandom_range(0, 3) == 0);
        branchb   = ($urandom_range(0, 3) == 0);
        offset    = 8'($urandom);
        dmem_ack  = ($urandom_range(0, 9) < 3);
        cycle();
      end
      clear_inputs();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
